// File: rtl/intr_sequencer_if.sv
// Handshake bundle between instruction decode/control and the interrupt sequencer.
// master: decode/control side driving strobes; slave: the sequencer.
interface intr_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             INTR;
  logic             I_SET;
  logic             I_CLR;
  logic             RETI;
  logic             RETI_IE;
  logic             BOUNDARY;
  logic             I_FLG;
  logic             INT_ACK;
  logic             FLG_SHAD_LD;
  logic             FLG_LD_SEL;
  logic             FLG_C_LD;
  logic             FLG_Z_LD;
  logic             IN_ISR;
  logic             RETI_ERR;
  logic [CNT_W-1:0] INT_CNT;

  modport master (
    output INTR, I_SET, I_CLR, RETI, RETI_IE, BOUNDARY,
    input  I_FLG, INT_ACK, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, IN_ISR, RETI_ERR,
           INT_CNT
  );

  modport slave (
    input  INTR, I_SET, I_CLR, RETI, RETI_IE, BOUNDARY,
    output I_FLG, INT_ACK, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, IN_ISR, RETI_ERR,
           INT_CNT
  );
endinterface

// File: rtl/intr_sequencer.sv
// Single-level interrupt sequencer: synchronizes INTR, latches a pending request,
// and walks IDLE -> SAVE -> ISR -> RESTORE, emitting flag save/restore strobes.
module intr_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input logic               CLK,
  input logic               RST,
  intr_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StSave, StIsr, StRestore} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q;
  logic             sync0_q, sync1_q, sync_prev_q;
  logic             pend_q;
  logic             i_flg_q;
  logic             in_isr_q;
  logic             int_ack_q;
  logic             shad_ld_q;
  logic             ld_sel_q;
  logic             c_ld_q;
  logic             z_ld_q;
  logic             reti_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic intr_rise;
  logic take_intr;

  assign intr_rise = sync1_q & ~sync_prev_q;
  assign take_intr = (state_q == StIdle) & pend_q & i_flg_q & bus.BOUNDARY;

  // Two-flop synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0_q     <= 1'b0;
      sync1_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync0_q     <= bus.INTR;
      sync1_q     <= sync0_q;
      sync_prev_q <= sync1_q;
    end
  end

  // Sequencer FSM with registered strobes; strobes are loaded on the edge entering
  // their state so they are high exactly while the FSM sits in that state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      i_flg_q    <= 1'b0;
      in_isr_q   <= 1'b0;
      int_ack_q  <= 1'b0;
      shad_ld_q  <= 1'b0;
      ld_sel_q   <= 1'b0;
      c_ld_q     <= 1'b0;
      z_ld_q     <= 1'b0;
      reti_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      int_ack_q  <= 1'b0;
      shad_ld_q  <= 1'b0;
      ld_sel_q   <= 1'b0;
      c_ld_q     <= 1'b0;
      z_ld_q     <= 1'b0;
      reti_err_q <= 1'b0;

      // A rise while already pending merges into the same request.
      if (intr_rise) pend_q <= 1'b1;

      // CLI beats SEI when both strobe together.
      if (bus.I_CLR)      i_flg_q <= 1'b0;
      else if (bus.I_SET) i_flg_q <= 1'b1;

      // RETI is only meaningful inside a handler.
      if (bus.RETI && (state_q != StIsr)) reti_err_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (take_intr) begin
            state_q   <= StSave;
            int_ack_q <= 1'b1;
            shad_ld_q <= 1'b1;
            pend_q    <= 1'b0;
            i_flg_q   <= 1'b0;
            if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
          end
        end
        StSave: begin
          state_q  <= StIsr;
          in_isr_q <= 1'b1;
        end
        StIsr: begin
          if (bus.RETI) begin
            state_q  <= StRestore;
            in_isr_q <= 1'b0;
            ld_sel_q <= 1'b1;
            c_ld_q   <= 1'b1;
            z_ld_q   <= 1'b1;
            i_flg_q  <= bus.RETI_IE;
          end
        end
        StRestore: begin
          state_q <= StIdle;
          // Hold the RETI-restored flag; SEI/CLI have no effect here.
          i_flg_q <= i_flg_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.I_FLG       = i_flg_q;
  assign bus.INT_ACK     = int_ack_q;
  assign bus.FLG_SHAD_LD = shad_ld_q;
  assign bus.FLG_LD_SEL  = ld_sel_q;
  assign bus.FLG_C_LD    = c_ld_q;
  assign bus.FLG_Z_LD    = z_ld_q;
  assign bus.IN_ISR      = in_isr_q;
  assign bus.RETI_ERR    = reti_err_q;
  assign bus.INT_CNT     = cnt_q;

endmodule
